mouse_player_ctl: RTL and testbench
===================================

// Module: mouse_player_ctl
// PURPOSE
//  Conditions raw MouseCtl data (x, y, left) for one player in the 65 MHz game domain.
//  Delays inputs by a parametrised pipeline, clamps them to the player's half-court, slew-limits once per tick,
//  muxes to an idle position when the mouse is disabled, and emits a one-cycle jump pulse with holdoff.
//  Sits between MouseCtl and the blob/game logic; one instance per player.
// PARAMETERS
//  PLAYER    1'b0  side: 0 = left half, 1 = right half
//  WIDTH     12    coordinate width (unsigned)
//  DELAY     2     input pipeline stages, 0..8 (0 = combinational pass)
//  X_EDGE_L  0     leftmost court x;  X_EDGE_R 1023 rightmost court x
//  X_SPLIT   512   net centre x;      NET_GAP  16   half-width of the excluded band at the net
//  Y_MIN     0     top y limit;       Y_MAX    679  bottom y limit
//  IDLE_X    50    position when disabled; IDLE_Y 679
//  MAX_STEP  8     max |delta| per axis per tick; 0 = no slew (snap)
//  HOLDOFF   32    clk cycles after a jump during which clicks are ignored
// PORTS
//  clk       in   1      game clock (65 MHz)
//  rst       in   1      asynchronous, active-low reset
//  enable    in   1      mousectl: 1 = follow mouse, 0 = idle
//  tick      in   1      1-cycle update strobe (e.g. once per frame)
//  xpos_in   in   WIDTH  raw mouse x;  ypos_in in WIDTH raw mouse y
//  left_in   in   1      raw left button level
//  xpos_out  out  WIDTH  conditioned x;  ypos_out out WIDTH conditioned y
//  left_out  out  1      button level, gated to TRACK
//  jump      out  1      one-cycle jump pulse
//  state     out  2      FSM state (debug)
// BEHAVIOUR
//  - Reset (rst=0, async): xpos_out=IDLE_X, ypos_out=IDLE_Y, left_out=0, jump=0, state=DISABLED,
//    pipeline regs=0, holdoff cnt=0, left edge reg=0.
//  - Pipeline: {left,x,y} delayed DELAY clks -> *_d. Target = clamp(*_d) registered 1 clk later.
//  - Window: P0 x in [X_EDGE_L, X_SPLIT-NET_GAP-1]; P1 x in [X_SPLIT+NET_GAP, X_EDGE_R]; y in [Y_MIN, Y_MAX].
//    Unsigned min/max clamp; out-of-range values saturate to the nearest bound.
//  - Slew, on tick only, per axis: d = tgt - out (WIDTH+1 signed); |d| <= MAX_STEP -> out = tgt,
//    else out += sign(d)*MAX_STEP. Outputs never leave the window (or idle) -> no wrap-around.
//  - FSM (evaluated each clk; enable sampled directly):
//    DISABLED: out held at idle; enable=1 -> ENTER.
//    ENTER: slews toward target; both axes at target after this tick's update -> TRACK.
//      enable=0 -> RETURN.
//    TRACK: slews toward target; enable=0 -> RETURN.
//    RETURN: slews toward (IDLE_X, IDLE_Y); reaches idle -> DISABLED; enable=1 -> ENTER.
//  - In RETURN the target is the idle point; the window clamp does not apply.
//  - left_out = left_d & (state==TRACK), registered.
//  - Jump: rising edge of left_d while state==TRACK and cnt==0 -> jump=1 for exactly 1 clk, cnt=HOLDOFF.
//    cnt decrements to 0 every clk. Click during ENTER/RETURN/holdoff: dropped, not queued.
//  - Simultaneous tick + click: both act in the same clk.
//    Tick with enable change: the state transition takes effect first; this tick's slew uses the new state's target.
//  - Latency: input -> target DELAY+1 clks; target -> out at the next tick; left_in edge -> jump DELAY+1 clks.
// STRUCTURE
//  - mouse_pkg (shared include): state encoding localparams
//    ST_DISABLED=0, ST_ENTER=1, ST_TRACK=2, ST_RETURN=3, plus window-helper constants.
//  - Pipeline reuses the existing delay module (WIDTH=2*WIDTH+1, CLK_DEL=DELAY).
//  - Sub-module axis_slew (WIDTH, MAX_STEP, IDLE): one clamp+slew register per axis, instantiated twice.
//  - Top holds the FSM, edge detect and holdoff counter.
// TESTING (defaults, PLAYER=0 -> x window [0,495])
//  1 Assert rst mid-run -> same clk: out=(50,679), jump=0, left_out=0, state=0.
//  2 enable=1, in=(300,600), tick every 10 clk -> x 58,66..300 after 32 ticks; y 671..600 after 10 ticks;
//    state ENTER -> TRACK on the 32nd tick.
//  3 TRACK, x_in=900 -> x settles 495. PLAYER=1 instance: x_in=100 -> 528. y_in=4000 -> 679.
//  4 TRACK, left_in rises at t, t+10, t+40 -> jump pulses at t+3 and t+43 only, each 1 clk wide.
//  5 enable=0 from TRACK at (300,600) -> RETURN, slews back to (50,679), then DISABLED;
//    clicks give left_out=0 and no jump.
//  6 MAX_STEP=0, DELAY=0 -> out snaps to the clamped input on the first tick; jump 1 clk after the edge.

Source files
------------

// File: rtl/mouse_player_ctl_pkg.sv
// Shared types and constants for the per-player mouse conditioning block.
// Holds the FSM state encoding and helpers that derive a player's x window.
package mouse_player_ctl_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENTER    = 2'd1,
        ST_TRACK    = 2'd2,
        ST_RETURN   = 2'd3
    } mouse_state_e;

    // Lowest legal x for a player: left player starts at the court edge,
    // right player starts just past the band around the net.
    function automatic int win_x_lo(bit player, int edge_l, int split, int gap);
        if (player) begin
            return split + gap;
        end else begin
            return edge_l;
        end
    endfunction

    // Highest legal x for a player: left player stops short of the net band,
    // right player runs to the court edge.
    function automatic int win_x_hi(bit player, int edge_r, int split, int gap);
        if (player) begin
            return edge_r;
        end else begin
            return split - gap - 1;
        end
    endfunction

endpackage

// File: rtl/mouse_player_ctl_if.sv
// Bundle of the MouseCtl-side inputs and game-side outputs for one player.
// master = the side producing mouse data, slave = the conditioning block.
interface mouse_player_ctl_if #(
    parameter int WIDTH = 12
);
    logic             enable;
    logic             tick;
    logic [WIDTH-1:0] xpos_in;
    logic [WIDTH-1:0] ypos_in;
    logic             left_in;
    logic [WIDTH-1:0] xpos_out;
    logic [WIDTH-1:0] ypos_out;
    logic             left_out;
    logic             jump;
    logic [1:0]       state;

    modport master (
        output enable, tick, xpos_in, ypos_in, left_in,
        input  xpos_out, ypos_out, left_out, jump, state
    );

    modport slave (
        input  enable, tick, xpos_in, ypos_in, left_in,
        output xpos_out, ypos_out, left_out, jump, state
    );
endinterface

// File: rtl/mouse_player_ctl_axis_slew.sv
// One coordinate axis: clamps the delayed raw value into [LO, HI], registers
// it as the target, and moves the output toward the selected target by at
// most MAX_STEP per tick (MAX_STEP = 0 snaps). When follow is low the target
// is the idle point and the clamp is bypassed.
module axis_slew #(
    parameter int WIDTH    = 12,
    parameter int MAX_STEP = 8,
    parameter int IDLE     = 0,
    parameter int LO       = 0,
    parameter int HI       = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             follow,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pos,
    output logic             reach
);

    localparam logic [WIDTH-1:0]        LO_V   = WIDTH'(LO);
    localparam logic [WIDTH-1:0]        HI_V   = WIDTH'(HI);
    localparam logic [WIDTH-1:0]        IDLE_V = WIDTH'(IDLE);
    localparam logic [WIDTH-1:0]        STEP_V = WIDTH'(MAX_STEP);
    localparam logic signed [WIDTH+1:0] LO_S   = (WIDTH+2)'(LO);
    localparam logic signed [WIDTH+1:0] HI_S   = (WIDTH+2)'(HI);
    localparam logic signed [WIDTH:0]   STEP_S = (WIDTH+1)'(MAX_STEP);
    localparam bit                      SNAP   = (MAX_STEP == 0);

    logic [WIDTH-1:0]        tgt_r;
    logic [WIDTH-1:0]        pos_r;
    logic [WIDTH-1:0]        clamped_s;
    logic [WIDTH-1:0]        sel_s;
    logic [WIDTH-1:0]        step_s;
    logic [WIDTH-1:0]        pos_next_s;
    logic signed [WIDTH+1:0] raw_s;
    logic signed [WIDTH:0]   diff_s;
    logic signed [WIDTH:0]   mag_s;

    // Saturate the raw coordinate into the player's window (signed compare avoids unsigned-zero corner cases).
    always_comb begin
        raw_s = $signed({2'b00, raw});
        if (raw_s < LO_S) begin
            clamped_s = LO_V;
        end else if (raw_s > HI_S) begin
            clamped_s = HI_V;
        end else begin
            clamped_s = raw;
        end
    end

    // Pick the target and compute the bounded step; the output only moves on tick.
    always_comb begin
        sel_s  = follow ? tgt_r : IDLE_V;
        diff_s = $signed({1'b0, sel_s}) - $signed({1'b0, pos_r});
        mag_s  = diff_s[WIDTH] ? -diff_s : diff_s;
        if (SNAP || (mag_s <= STEP_S)) begin
            step_s = sel_s;
        end else if (diff_s[WIDTH]) begin
            step_s = pos_r - STEP_V;
        end else begin
            step_s = pos_r + STEP_V;
        end
        if (tick) begin
            pos_next_s = step_s;
        end else begin
            pos_next_s = pos_r;
        end
    end

    // Target and position registers; position rests at the idle point after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_r <= LO_V;
            pos_r <= IDLE_V;
        end else begin
            tgt_r <= clamped_s;
            pos_r <= pos_next_s;
        end
    end

    assign pos   = pos_r;
    assign reach = (pos_next_s == sel_s);

endmodule

// File: rtl/mouse_player_ctl_delay.sv
// Generic fixed-latency delay line: CLK_DEL register stages, or a plain
// wire when CLK_DEL is zero. All stages clear on reset.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (CLK_DEL == 0) begin : g_pass
        logic unused_s;
        assign unused_s = clk ^ rst;
        assign dout     = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_r [CLK_DEL];

        // Shift the input through CLK_DEL register stages.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < CLK_DEL; i++) begin
                    stage_r[i] <= '0;
                end
            end else begin
                stage_r[0] <= din;
                for (int i = 1; i < CLK_DEL; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign dout = stage_r[CLK_DEL-1];
    end

endmodule

// File: rtl/mouse_player_ctl.sv
// Per-player mouse conditioning: delays raw MouseCtl data, clamps and
// slew-limits the position per axis, parks the blob at an idle point when the
// mouse is disabled, and turns left clicks into single-cycle jump pulses with
// a holdoff window. The FSM decides whether the axes chase the mouse or idle.
module mouse_player_ctl
    import mouse_player_ctl_pkg::*;
#(
    parameter bit PLAYER   = 1'b0,
    parameter int WIDTH    = 12,
    parameter int DELAY    = 2,
    parameter int X_EDGE_L = 0,
    parameter int X_EDGE_R = 1023,
    parameter int X_SPLIT  = 512,
    parameter int NET_GAP  = 16,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 679,
    parameter int IDLE_X   = 50,
    parameter int IDLE_Y   = 679,
    parameter int MAX_STEP = 8,
    parameter int HOLDOFF  = 32
) (
    input  logic                clk,
    input  logic                rst,
    mouse_player_ctl_if.slave   bus
);

    localparam int              CNT_W    = $clog2(HOLDOFF + 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLDOFF);

    logic [2*WIDTH:0] pipe_in_s;
    logic [2*WIDTH:0] pipe_out_s;
    logic             left_d_s;
    logic [WIDTH-1:0] x_d_s;
    logic [WIDTH-1:0] y_d_s;
    logic [WIDTH-1:0] x_pos_s;
    logic [WIDTH-1:0] y_pos_s;
    logic             x_reach_s;
    logic             y_reach_s;

    mouse_state_e     state_r;
    mouse_state_e     state_next_s;
    logic             left_prev_r;
    logic             left_out_r;
    logic             jump_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fire_s;

    assign pipe_in_s = {bus.left_in, bus.xpos_in, bus.ypos_in};

    delay #(
        .WIDTH   (2*WIDTH+1),
        .CLK_DEL (DELAY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (pipe_in_s),
        .dout (pipe_out_s)
    );

    assign left_d_s = pipe_out_s[2*WIDTH];
    assign x_d_s    = pipe_out_s[2*WIDTH-1:WIDTH];
    assign y_d_s    = pipe_out_s[WIDTH-1:0];

    axis_slew #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP),
        .IDLE     (IDLE_X),
        .LO       (win_x_lo(PLAYER, X_EDGE_L, X_SPLIT, NET_GAP)),
        .HI       (win_x_hi(PLAYER, X_EDGE_R, X_SPLIT, NET_GAP))
    ) u_x (
        .clk    (clk),
        .rst    (rst),
        .tick   (bus.tick),
        .follow (bus.enable),
        .raw    (x_d_s),
        .pos    (x_pos_s),
        .reach  (x_reach_s)
    );

    axis_slew #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP),
        .IDLE     (IDLE_Y),
        .LO       (Y_MIN),
        .HI       (Y_MAX)
    ) u_y (
        .clk    (clk),
        .rst    (rst),
        .tick   (bus.tick),
        .follow (bus.enable),
        .raw    (y_d_s),
        .pos    (y_pos_s),
        .reach  (y_reach_s)
    );

    // Next-state logic. Target selection follows enable directly, so any
    // enable change on a tick already steers that tick's slew.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_DISABLED: begin
                if (bus.enable) begin
                    state_next_s = ST_ENTER;
                end else begin
                    state_next_s = ST_DISABLED;
                end
            end
            ST_ENTER: begin
                if (!bus.enable) begin
                    state_next_s = ST_RETURN;
                end else if (bus.tick && x_reach_s && y_reach_s) begin
                    state_next_s = ST_TRACK;
                end else begin
                    state_next_s = ST_ENTER;
                end
            end
            ST_TRACK: begin
                if (!bus.enable) begin
                    state_next_s = ST_RETURN;
                end else begin
                    state_next_s = ST_TRACK;
                end
            end
            ST_RETURN: begin
                if (bus.enable) begin
                    state_next_s = ST_ENTER;
                end else if (x_reach_s && y_reach_s) begin
                    state_next_s = ST_DISABLED;
                end else begin
                    state_next_s = ST_RETURN;
                end
            end
            default: begin
                state_next_s = ST_DISABLED;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_DISABLED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // A click only fires when tracking and outside the holdoff window; others are dropped.
    assign fire_s = left_d_s && !left_prev_r && (state_r == ST_TRACK) && (cnt_r == '0);

    // Edge detect, gated button level, jump pulse and holdoff counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_prev_r <= 1'b0;
            left_out_r  <= 1'b0;
            jump_r      <= 1'b0;
            cnt_r       <= '0;
        end else begin
            left_prev_r <= left_d_s;
            left_out_r  <= left_d_s && (state_r == ST_TRACK);
            jump_r      <= fire_s;
            if (fire_s) begin
                cnt_r <= CNT_INIT;
            end else if (cnt_r != '0) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign bus.xpos_out = x_pos_s;
    assign bus.ypos_out = y_pos_s;
    assign bus.left_out = left_out_r;
    assign bus.jump     = jump_r;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_mouse_player_ctl.sv
// Directed bench for mouse_player_ctl: a default left-player instance, a
// right-player instance, and a snap/no-delay instance sharing one tick.
module tb_mouse_player_ctl;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   jump_seen;
    int   lout_seen;

    always #5 clk = ~clk;

    mouse_player_ctl_if #(.WIDTH(12)) if_a ();
    mouse_player_ctl_if #(.WIDTH(12)) if_b ();
    mouse_player_ctl_if #(.WIDTH(12)) if_c ();

    assign if_a.tick = tick;
    assign if_b.tick = tick;
    assign if_c.tick = tick;

    mouse_player_ctl #(.PLAYER(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mouse_player_ctl #(.PLAYER(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    mouse_player_ctl #(.PLAYER(1'b0), .MAX_STEP(0), .DELAY(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-clock tick pulse, then idle so each call spans 10 clocks.
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b0;
        tick = 1'b0;
        if_a.enable = 1'b0; if_a.xpos_in = '0; if_a.ypos_in = '0; if_a.left_in = 1'b0;
        if_b.enable = 1'b0; if_b.xpos_in = '0; if_b.ypos_in = '0; if_b.left_in = 1'b0;
        if_c.enable = 1'b0; if_c.xpos_in = '0; if_c.ypos_in = '0; if_c.left_in = 1'b0;
        wait_clk(3);

        // Reset state
        check_val("rst_x", 32'(if_a.xpos_out), 32'd50);
        check_val("rst_y", 32'(if_a.ypos_out), 32'd679);
        check_val("rst_state", 32'(if_a.state), 32'd0);
        check_val("rst_jump", 32'(if_a.jump), 32'd0);
        check_val("rst_lout", 32'(if_a.left_out), 32'd0);
        rst = 1'b1;
        wait_clk(2);

        // Enter and slew toward (300,600)
        if_a.xpos_in = 12'd300;
        if_a.ypos_in = 12'd600;
        wait_clk(5);
        check_val("dis_hold_x", 32'(if_a.xpos_out), 32'd50);
        if_a.enable = 1'b1;
        wait_clk(1);
        check_val("enter_state", 32'(if_a.state), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            do_tick();
            if (i == 1) begin
                check_val("t1_x", 32'(if_a.xpos_out), 32'd58);
                check_val("t1_y", 32'(if_a.ypos_out), 32'd671);
            end
            if (i == 10) begin
                check_val("t10_x", 32'(if_a.xpos_out), 32'd130);
                check_val("t10_y", 32'(if_a.ypos_out), 32'd600);
            end
            if (i == 31) begin
                check_val("t31_x", 32'(if_a.xpos_out), 32'd298);
                check_val("t31_state", 32'(if_a.state), 32'd1);
            end
            if (i == 32) begin
                check_val("t32_x", 32'(if_a.xpos_out), 32'd300);
                check_val("t32_state", 32'(if_a.state), 32'd2);
            end
        end

        // Clamp to the left half-court and the bottom limit
        if_a.xpos_in = 12'd900;
        if_a.ypos_in = 12'd4000;
        repeat (30) do_tick();
        check_val("clamp_x", 32'(if_a.xpos_out), 32'd495);
        check_val("clamp_y", 32'(if_a.ypos_out), 32'd679);
        if_a.xpos_in = 12'd300;
        if_a.ypos_in = 12'd600;
        repeat (30) do_tick();
        check_val("back_x", 32'(if_a.xpos_out), 32'd300);
        check_val("back_y", 32'(if_a.ypos_out), 32'd600);
        check_val("track_state", 32'(if_a.state), 32'd2);

        // Clicks at k=0,10,40 (3 clocks each): jumps only at k=3 and k=43
        for (int k = 0; k <= 50; k++) begin
            if (k > 0) begin
                check_val($sformatf("jump_k%0d", k), 32'(if_a.jump), ((k == 3) || (k == 43)) ? 32'd1 : 32'd0);
            end
            if (k == 3) check_val("lout_k3", 32'(if_a.left_out), 32'd1);
            if (k == 7) check_val("lout_k7", 32'(if_a.left_out), 32'd0);
            if_a.left_in = ((k <= 2) || (k >= 10 && k <= 12) || (k >= 40 && k <= 42)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end

        // Disable: return to idle, clicks ignored
        if_a.enable = 1'b0;
        wait_clk(1);
        check_val("return_state", 32'(if_a.state), 32'd3);
        jump_seen = 0;
        lout_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if_a.left_in = (k < 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (if_a.jump) jump_seen++;
            if (if_a.left_out) lout_seen++;
        end
        check_val("ret_click_jump", 32'(jump_seen), 32'd0);
        check_val("ret_click_lout", 32'(lout_seen), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            do_tick();
            if (i == 31) begin
                check_val("r31_x", 32'(if_a.xpos_out), 32'd52);
                check_val("r31_y", 32'(if_a.ypos_out), 32'd679);
                check_val("r31_state", 32'(if_a.state), 32'd3);
            end
            if (i == 32) begin
                check_val("r32_x", 32'(if_a.xpos_out), 32'd50);
                check_val("r32_state", 32'(if_a.state), 32'd0);
            end
        end
        jump_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if_a.left_in = (k < 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (if_a.jump) jump_seen++;
        end
        check_val("dis_click_jump", 32'(jump_seen), 32'd0);

        // Right player clamps to the right of the net band
        if_b.xpos_in = 12'd100;
        if_b.ypos_in = 12'd100;
        wait_clk(5);
        if_b.enable = 1'b1;
        repeat (80) do_tick();
        check_val("p1_x", 32'(if_b.xpos_out), 32'd528);
        check_val("p1_y", 32'(if_b.ypos_out), 32'd100);
        check_val("p1_state", 32'(if_b.state), 32'd2);

        // No slew, no delay: snap on first tick, jump one clock after the edge
        if_c.xpos_in = 12'd900;
        if_c.ypos_in = 12'd4000;
        wait_clk(2);
        if_c.enable = 1'b1;
        wait_clk(1);
        check_val("snap_pre_state", 32'(if_c.state), 32'd1);
        do_tick();
        check_val("snap_x", 32'(if_c.xpos_out), 32'd495);
        check_val("snap_y", 32'(if_c.ypos_out), 32'd679);
        check_val("snap_state", 32'(if_c.state), 32'd2);
        if_c.left_in = 1'b1;
        wait_clk(1);
        check_val("snap_jump1", 32'(if_c.jump), 32'd1);
        wait_clk(1);
        check_val("snap_jump2", 32'(if_c.jump), 32'd0);
        check_val("snap_lout", 32'(if_c.left_out), 32'd1);

        // Asynchronous reset mid-run
        rst = 1'b0;
        #1;
        check_val("arst_x", 32'(if_b.xpos_out), 32'd50);
        check_val("arst_y", 32'(if_b.ypos_out), 32'd679);
        check_val("arst_state", 32'(if_b.state), 32'd0);
        check_val("arst_jump", 32'(if_b.jump), 32'd0);
        check_val("arst_lout", 32'(if_c.left_out), 32'd0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
